div_clk_gen: RTL and testbench

Multi-channel, runtime-programmable clock-enable/divided-clock generator clocked from `sys_clk`. Each channel produces a registered divided level output with programmable period and high time, and a one-cycle tick strobe per period. It supersedes the fixed single-output divider: duty cycle, per-channel enable, glitch-free reconfiguration at period boundaries, and a global phase-align restart are new. Consumers are peripheral timing (scan, PWM, sampling), preferably using `tick` as a clock enable.

---
 rtl/div_clk_gen.sv | 123 ++++++++++++
 tb/tb_div_clk_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div_clk_gen.sv
// rtl/div_clk_gen.sv - multi-channel programmable divided-clock / tick generator
// Shadowed per-channel period/high config is applied only at period boundaries, on idle or on restart.
module div_clk_gen #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 24,
  parameter int DEF_PERIOD = 1666,
  parameter int DEF_HIGH   = 833
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_restart,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic [CHANNELS-1:0] cfg_pending,
  output logic [CHANNELS-1:0] div_clk,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] P_DEF = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] H_DEF = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_n   [CHANNELS];
  logic [CNT_W-1:0] p_act_q [CHANNELS];
  logic [CNT_W-1:0] p_n     [CHANNELS];
  logic [CNT_W-1:0] h_act_q [CHANNELS];
  logic [CNT_W-1:0] h_n     [CHANNELS];
  logic [CNT_W-1:0] p_sh_q  [CHANNELS];
  logic [CNT_W-1:0] p_sh_n  [CHANNELS];
  logic [CNT_W-1:0] h_sh_q  [CHANNELS];
  logic [CNT_W-1:0] h_sh_n  [CHANNELS];

  logic [CHANNELS-1:0] pend_q, pend_n;
  logic [CHANNELS-1:0] run_q;
  logic [CHANNELS-1:0] div_q, div_n;
  logic [CHANNELS-1:0] tick_q, tick_n;
  logic [CHANNELS-1:0] wr, wrap, start, apply;

  logic [CNT_W-1:0] p_wr, h_wr;

  always_comb begin
    p_wr = (cfg_period < P_MIN) ? P_MIN : cfg_period;
    h_wr = (cfg_high > p_wr) ? p_wr : cfg_high;
  end

  // A channel leaving idle starts its first period at cnt=0 so that period is a full P cycles.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_n[i]  = cnt_q[i];
      p_n[i]    = p_act_q[i];
      h_n[i]    = h_act_q[i];
      p_sh_n[i] = p_sh_q[i];
      h_sh_n[i] = h_sh_q[i];
      pend_n[i] = pend_q[i];
      div_n[i]  = 1'b0;
      tick_n[i] = 1'b0;

      wr[i]    = cfg_we && (cfg_ch == 4'(i));
      start[i] = en[i] && !run_q[i];
      wrap[i]  = en[i] && (cnt_q[i] == p_act_q[i] - ONE);
      apply[i] = pend_q[i] && (sync_restart || !en[i] || start[i] || wrap[i]);

      if (apply[i]) begin
        p_n[i]    = p_sh_q[i];
        h_n[i]    = h_sh_q[i];
        pend_n[i] = 1'b0;
      end
      // A write colliding with an apply lands in the shadow and keeps pend set.
      if (wr[i]) begin
        p_sh_n[i] = p_wr;
        h_sh_n[i] = h_wr;
        pend_n[i] = 1'b1;
      end

      if (!en[i] || sync_restart || start[i] || wrap[i]) begin
        cnt_n[i] = '0;
      end else begin
        cnt_n[i] = cnt_q[i] + ONE;
      end

      div_n[i]  = en[i] && (cnt_n[i] < h_n[i]);
      tick_n[i] = en[i] && (cnt_n[i] == p_n[i] - ONE);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= '0;
        p_act_q[i] <= P_DEF;
        h_act_q[i] <= H_DEF;
        p_sh_q[i]  <= P_DEF;
        h_sh_q[i]  <= H_DEF;
      end
      pend_q <= '0;
      run_q  <= '0;
      div_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= cnt_n[i];
        p_act_q[i] <= p_n[i];
        h_act_q[i] <= h_n[i];
        p_sh_q[i]  <= p_sh_n[i];
        h_sh_q[i]  <= h_sh_n[i];
      end
      pend_q <= pend_n;
      run_q  <= en;
      div_q  <= div_n;
      tick_q <= tick_n;
    end
  end

  assign cfg_pending = pend_q;
  assign div_clk     = div_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_div_clk_gen.sv
// tb/tb_div_clk_gen.sv - directed scoreboard bench for div_clk_gen
// Expected div/tick/pending per cycle are queued as stimulus advances and popped after each edge.
module tb_div_clk_gen;

  localparam int CH    = 4;
  localparam int CNT_W = 24;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    en;
  logic             sync_restart;
  logic             cfg_we;
  logic [3:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [CH-1:0]    cfg_pending;
  logic [CH-1:0]    div_clk;
  logic [CH-1:0]    tick;

  typedef struct {
    logic [CH-1:0] m;
    logic          d;
    logic          t;
    logic          p;
    int            c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 sys_clk = ~sys_clk;

  div_clk_gen #(
    .CHANNELS  (CH),
    .CNT_W     (CNT_W),
    .DEF_PERIOD(1666),
    .DEF_HIGH  (833)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .en          (en),
    .sync_restart(sync_restart),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_pending (cfg_pending),
    .div_clk     (div_clk),
    .tick        (tick)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    cfg_we       = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int p, input int h);
    cfg_we     = 1'b1;
    cfg_ch     = 4'(ch);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
  endtask

  task automatic program_idle(input int ch, input int p, input int h);
    en[ch] = 1'b0;
    cfg_write(ch, p, h);
    step();
    step();
    en[ch] = 1'b1;
  endtask

  // Cycle c of a period P with high time H: high while c%P < H, tick on the last cycle.
  task automatic expect_seg(input logic [CH-1:0] mask, input int p, input int h,
                            input int c0, input int c1, input logic pend);
    exp_t e;
    for (int c = c0; c < c1; c++) begin
      e.m = mask;
      e.d = ((c % p) < h);
      e.t = ((c % p) == p - 1);
      e.p = pend;
      e.c = c;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      chk("div_clk", e.c, 32'(div_clk & e.m), 32'(e.d ? e.m : '0));
      chk("tick", e.c, 32'(tick & e.m), 32'(e.t ? e.m : '0));
      chk("cfg_pending", e.c, 32'(cfg_pending & e.m), 32'(e.p ? e.m : '0));
    end
  endtask

  initial begin
    rst          = 1'b1;
    en           = '0;
    sync_restart = 1'b0;
    cfg_we       = 1'b0;
    cfg_ch       = '0;
    cfg_period   = '0;
    cfg_high     = '0;
    repeat (3) step();
    chk("rst_div", 0, 32'(div_clk), 32'h0);
    chk("rst_tick", 0, 32'(tick), 32'h0);
    chk("rst_pend", 0, 32'(cfg_pending), 32'h0);

    rst = 1'b0;
    step();
    en[0] = 1'b1;
    expect_seg(4'b0001, 1666, 833, 0, 3332, 1'b0);

    cfg_write(1, 10, 3);
    step();
    chk("pend_set", 0, 32'(cfg_pending), 32'h2);
    step();
    chk("pend_idle_apply", 0, 32'(cfg_pending), 32'h0);
    chk("div_idle", 0, 32'(div_clk[1]), 32'h0);
    en[1] = 1'b1;
    expect_seg(4'b0010, 10, 3, 0, 30, 1'b0);
    program_idle(1, 10, 0);
    expect_seg(4'b0010, 10, 0, 0, 20, 1'b0);
    program_idle(1, 10, 10);
    expect_seg(4'b0010, 10, 10, 0, 20, 1'b0);

    program_idle(2, 8, 4);
    expect_seg(4'b0100, 8, 4, 0, 3, 1'b0);
    cfg_write(2, 5, 1);
    expect_seg(4'b0100, 8, 4, 3, 8, 1'b1);
    expect_seg(4'b0100, 5, 1, 0, 10, 1'b0);

    expect_seg(4'b0100, 5, 1, 0, 2, 1'b0);
    cfg_write(2, 6, 1);
    expect_seg(4'b0100, 5, 1, 2, 5, 1'b1);
    cfg_write(2, 12, 1);
    expect_seg(4'b0100, 6, 1, 0, 6, 1'b1);
    expect_seg(4'b0100, 12, 1, 0, 24, 1'b0);

    program_idle(3, 0, 7);
    expect_seg(4'b1000, 2, 2, 0, 6, 1'b0);
    cfg_write(5, 3, 1);
    expect_seg(4'b1000, 2, 2, 6, 12, 1'b0);
    chk("ignore_pend", 0, 32'(cfg_pending), 32'h0);

    program_idle(0, 7, 3);
    repeat (3) step();
    program_idle(3, 7, 3);
    step();
    sync_restart = 1'b1;
    expect_seg(4'b1001, 7, 3, 0, 21, 1'b0);

    cfg_write(1, 4, 2);
    step();
    chk("pend_before_rst", 0, 32'(cfg_pending[1]), 32'h1);
    rst = 1'b1;
    en  = 4'b0001;
    step();
    chk("rst_mid_div", 0, 32'(div_clk), 32'h0);
    chk("rst_mid_tick", 0, 32'(tick), 32'h0);
    chk("rst_mid_pend", 0, 32'(cfg_pending), 32'h0);
    rst = 1'b0;
    expect_seg(4'b0001, 1666, 833, 0, 840, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
